// File: rtl/usb_ft245_pkg.sv
// Shared definitions for the FT232H async-245 bridge.
//   ft_state_t : strobe sequencer states
//   DEF_*      : default timing constants (in clk cycles) and FIFO depth
//   CNT_W      : width of the strobe/recovery cycle counter
package usb_ft245_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WR_SETUP,
    ST_WRITE,
    ST_RECOVER
  } ft_state_t;

  localparam int DEF_DEPTH_LOG2      = 4;
  localparam int DEF_RD_CYCLES       = 5;
  localparam int DEF_WR_CYCLES       = 4;
  localparam int DEF_RECOVERY_CYCLES = 4;
  localparam int CNT_W               = 8;

endpackage

// File: rtl/usb_byte_fifo.sv
// Synchronous byte FIFO with registered read data.
//   clk, reset : clock and synchronous active-high reset
//   flush      : empties the FIFO; wins over a same-cycle push or pop
//   push/wdata : write one byte; dropped when full unless a pop happens in the same cycle
//   pop/rdata  : read one byte; rdata updates on the next edge, holds on an empty pop
//   count      : occupancy, registered
//   full/empty : decoded straight from the count register
// Port semantics: push and pop are single-cycle requests with no ready; a
// request that cannot be honoured (push on full, pop on empty) has no effect.
module usb_byte_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push,
  input  logic [7:0]            wdata,
  input  logic                  pop,
  output logic [7:0]            rdata,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int                  DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] ONE   = 1;

  logic [7:0]          mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0] count_q, count_d;
  logic [7:0]          rdata_q, rdata_d;
  logic                push_ok, pop_ok;

  assign full  = count_q[DEPTH_LOG2];
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = rdata_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rdata_d  = rdata_q;
    pop_ok   = pop && !empty && !flush;
    // A pop in the same cycle frees a slot, so a push at full is still taken.
    push_ok  = push && !flush && (!full || pop_ok);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + ONE;
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + ONE;
        rdata_d  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + ONE;
        2'b01:   count_d = count_q - ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wdata;
  end

endmodule

// File: rtl/usb_ft245_bridge.sv
// Bridge between an FT232H in async 245 FIFO mode and a byte FIFO port.
//   clk, reset             : clock, synchronous active-high reset
//   rx_flush, tx_flush     : single-cycle pulses emptying the RX / TX FIFO
//   rx_read/rx_rdata       : pop side of the RX FIFO (data the cycle after rx_read)
//   rx_empty, rx_count     : RX FIFO status
//   tx_write/tx_wdata      : push side of the TX FIFO (dropped when full)
//   tx_full, tx_count      : TX FIFO status
//   usb_rxf_n, usb_txe_n   : asynchronous chip status flags (active low)
//   usb_rd_n, usb_wr_n     : chip strobes, registered
//   usb_data_in/out, _oe   : pad data; tristate buffer lives above this block
//   dbg_state              : current sequencer state
module usb_ft245_bridge
  import usb_ft245_pkg::*;
#(
  parameter int DEPTH_LOG2      = DEF_DEPTH_LOG2,
  parameter int RD_CYCLES       = DEF_RD_CYCLES,
  parameter int WR_CYCLES       = DEF_WR_CYCLES,
  parameter int RECOVERY_CYCLES = DEF_RECOVERY_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx_flush,
  input  logic                tx_flush,
  output logic                rx_empty,
  input  logic                rx_read,
  output logic [7:0]          rx_rdata,
  output logic                tx_full,
  input  logic                tx_write,
  input  logic [7:0]          tx_wdata,
  output logic [DEPTH_LOG2:0] rx_count,
  output logic [DEPTH_LOG2:0] tx_count,
  input  logic                usb_rxf_n,
  input  logic                usb_txe_n,
  output logic                usb_rd_n,
  output logic                usb_wr_n,
  input  logic [7:0]          usb_data_in,
  output logic [7:0]          usb_data_out,
  output logic                usb_data_oe,
  output ft_state_t           dbg_state
);

  if (RECOVERY_CYCLES < 3) begin : g_recovery_check
    $error("RECOVERY_CYCLES must be at least 3");
  end
  if (RD_CYCLES < 1 || WR_CYCLES < 1 || RD_CYCLES > 256 || WR_CYCLES > 256 ||
      RECOVERY_CYCLES > 256) begin : g_timing_check
    $error("strobe timing parameters must be in 1..256");
  end

  localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'(WR_CYCLES - 1);
  localparam logic [CNT_W-1:0] REC_LOAD = CNT_W'(RECOVERY_CYCLES - 1);

  ft_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_n_q, rd_n_d;
  logic             wr_n_q, wr_n_d;
  logic             oe_q, oe_d;
  logic             prio_rx_q, prio_rx_d;   // 1: RX wins a tie
  logic             discard_q, discard_d;   // RX flushed during the current read
  logic             rxf_meta_q, rxf_meta_d, rxf_sync_q, rxf_sync_d;
  logic             txe_meta_q, txe_meta_d, txe_sync_q, txe_sync_d;

  logic             rx_push, tx_pop, rx_full, tx_empty;
  logic             rx_elig, tx_elig;

  usb_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (rx_flush),
    .push  (rx_push),
    .wdata (usb_data_in),
    .pop   (rx_read),
    .rdata (rx_rdata),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // The TX read register drives the pads directly: only the sequencer pops
  // this FIFO, so the byte stays put through the whole write, even across a flush.
  usb_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (tx_flush),
    .push  (tx_write),
    .wdata (tx_wdata),
    .pop   (tx_pop),
    .rdata (usb_data_out),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty)
  );

  assign usb_rd_n    = rd_n_q;
  assign usb_wr_n    = wr_n_q;
  assign usb_data_oe = oe_q;
  assign dbg_state   = state_q;

  always_comb begin
    rxf_meta_d = usb_rxf_n;
    rxf_sync_d = rxf_meta_q;
    txe_meta_d = usb_txe_n;
    txe_sync_d = txe_meta_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_n_d    = 1'b1;
    wr_n_d    = 1'b1;
    oe_d      = 1'b0;
    prio_rx_d = prio_rx_q;
    discard_d = discard_q;
    rx_push   = 1'b0;
    tx_pop    = 1'b0;
    rx_elig   = !rxf_sync_q && !rx_full;
    // A flush in the decision cycle would cancel the pop, so hold off TX.
    tx_elig   = !txe_sync_q && !tx_empty && !tx_flush;
    case (state_q)
      ST_IDLE: begin
        if (rx_elig && (!tx_elig || prio_rx_q)) begin
          state_d   = ST_READ;
          cnt_d     = RD_LOAD;
          rd_n_d    = 1'b0;
          prio_rx_d = 1'b0;
          discard_d = 1'b0;
        end else if (tx_elig) begin
          state_d   = ST_WR_SETUP;
          tx_pop    = 1'b1;
          oe_d      = 1'b1;
          prio_rx_d = 1'b1;
        end
      end
      ST_READ: begin
        if (rx_flush) discard_d = 1'b1;
        if (cnt_q == '0) begin
          rx_push = !discard_q;
          state_d = ST_RECOVER;
          cnt_d   = REC_LOAD;
        end else begin
          rd_n_d = 1'b0;
          cnt_d  = cnt_q - 1'b1;
        end
      end
      ST_WR_SETUP: begin
        oe_d    = 1'b1;
        wr_n_d  = 1'b0;
        state_d = ST_WRITE;
        cnt_d   = WR_LOAD;
      end
      ST_WRITE: begin
        // oe stays up through the cycle after wr_n rises for data hold.
        oe_d = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_RECOVER;
          cnt_d   = REC_LOAD;
        end else begin
          wr_n_d = 1'b0;
          cnt_d  = cnt_q - 1'b1;
        end
      end
      ST_RECOVER: begin
        // Long enough for the flag synchronizers to reflect the chip's response.
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      oe_q       <= 1'b0;
      prio_rx_q  <= 1'b1;
      discard_q  <= 1'b0;
      rxf_meta_q <= 1'b1;
      rxf_sync_q <= 1'b1;
      txe_meta_q <= 1'b1;
      txe_sync_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_n_q     <= rd_n_d;
      wr_n_q     <= wr_n_d;
      oe_q       <= oe_d;
      prio_rx_q  <= prio_rx_d;
      discard_q  <= discard_d;
      rxf_meta_q <= rxf_meta_d;
      rxf_sync_q <= rxf_sync_d;
      txe_meta_q <= txe_meta_d;
      txe_sync_q <= txe_sync_d;
    end
  end

endmodule

// File: tb/tb_usb_ft245_bridge.sv
// Directed bench for usb_ft245_bridge with a small FT232H chip model.
module tb_usb_ft245_bridge;
  import usb_ft245_pkg::*;

  localparam int DL = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx_flush = 1'b0, tx_flush = 1'b0, rx_read = 1'b0, tx_write = 1'b0;
  logic [7:0]    tx_wdata = 8'h00;
  logic          rx_empty, tx_full;
  logic [7:0]    rx_rdata;
  logic [DL:0]   rx_count, tx_count;
  logic          usb_rxf_n = 1'b1;
  logic          chip_txe_n = 1'b1;
  logic          usb_rd_n, usb_wr_n, usb_data_oe;
  logic [7:0]    usb_data_in = 8'h00;
  logic [7:0]    usb_data_out;
  ft_state_t     dbg_state;

  int asserts = 0;
  int failures = 0;

  // chip model and monitor state
  logic [7:0] chip_rx_q[$];
  logic [7:0] chip_tx_got[$];
  logic [7:0] strobe_log[$];
  int         rd_len_q[$], wr_len_q[$], gap_q[$];
  int         mon_err = 0, setup_err = 0;
  logic       prev_rd = 1'b1, prev_wr = 1'b1, prev_oe = 1'b0;
  logic [7:0] prev_data = 8'h00;
  int         rd_run = 0, wr_run = 0, idle_run = 0;
  bit         have_prev = 1'b0;

  usb_ft245_bridge dut (
    .clk          (clk),
    .reset        (reset),
    .rx_flush     (rx_flush),
    .tx_flush     (tx_flush),
    .rx_empty     (rx_empty),
    .rx_read      (rx_read),
    .rx_rdata     (rx_rdata),
    .tx_full      (tx_full),
    .tx_write     (tx_write),
    .tx_wdata     (tx_wdata),
    .rx_count     (rx_count),
    .tx_count     (tx_count),
    .usb_rxf_n    (usb_rxf_n),
    .usb_txe_n    (chip_txe_n),
    .usb_rd_n     (usb_rd_n),
    .usb_wr_n     (usb_wr_n),
    .usb_data_in  (usb_data_in),
    .usb_data_out (usb_data_out),
    .usb_data_oe  (usb_data_oe),
    .dbg_state    (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected test end");
    $fatal(1, "watchdog");
  end

  // Chip model + strobe monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      prev_rd = 1'b1; prev_wr = 1'b1; prev_oe = 1'b0;
      rd_run = 0; wr_run = 0; idle_run = 0; have_prev = 1'b0;
    end else begin
      if (!usb_rd_n && !usb_wr_n) mon_err++;
      if (!usb_rd_n && usb_data_oe) mon_err++;
      if (prev_rd && !usb_rd_n) begin
        strobe_log.push_back(8'h52);
        if (have_prev) gap_q.push_back(idle_run);
        idle_run = 0; have_prev = 1'b1;
      end
      if (prev_wr && !usb_wr_n) begin
        strobe_log.push_back(8'h57);
        if (have_prev) gap_q.push_back(idle_run);
        idle_run = 0; have_prev = 1'b1;
        chip_tx_got.push_back(usb_data_out);
        if (!(prev_oe && prev_data == usb_data_out)) setup_err++;
      end
      if (!usb_rd_n) rd_run++;
      else if (!prev_rd) begin
        rd_len_q.push_back(rd_run);
        rd_run = 0;
        if (chip_rx_q.size() > 0) void'(chip_rx_q.pop_front());
      end
      if (!usb_wr_n) wr_run++;
      else if (!prev_wr) begin
        wr_len_q.push_back(wr_run);
        wr_run = 0;
      end
      if (usb_rd_n && usb_wr_n) idle_run++;
      prev_rd = usb_rd_n; prev_wr = usb_wr_n; prev_oe = usb_data_oe;
      prev_data = usb_data_out;
    end
    usb_rxf_n   = (chip_rx_q.size() == 0);
    usb_data_in = (chip_rx_q.size() > 0) ? chip_rx_q[0] : 8'h00;
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    chip_tx_got.delete(); strobe_log.delete();
    rd_len_q.delete(); wr_len_q.delete(); gap_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; rx_flush = 1'b0; tx_flush = 1'b0; rx_read = 1'b0;
    tx_write = 1'b0; tx_wdata = 8'h00; chip_txe_n = 1'b1;
    chip_rx_q.delete();
    tick(3);
    reset = 1'b0;
    tick(1);
    clear_logs();
  endtask

  task automatic pop_rx();
    rx_read = 1'b1;
    tick(1);
    rx_read = 1'b0;
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_write = 1'b1; tx_wdata = b;
    tick(1);
    tx_write = 1'b0;
  endtask

  // tests
  task automatic test_reset();
    do_reset();
    asserts++; if (usb_rd_n !== 1'b1) begin failures++; $display("FAIL reset_rd_n: got %b expected 1", usb_rd_n); end
    asserts++; if (usb_wr_n !== 1'b1) begin failures++; $display("FAIL reset_wr_n: got %b expected 1", usb_wr_n); end
    asserts++; if (usb_data_oe !== 1'b0) begin failures++; $display("FAIL reset_oe: got %b expected 0", usb_data_oe); end
    asserts++; if (usb_data_out !== 8'h00) begin failures++; $display("FAIL reset_data_out: got %h expected 00", usb_data_out); end
    asserts++; if (rx_rdata !== 8'h00) begin failures++; $display("FAIL reset_rx_rdata: got %h expected 00", rx_rdata); end
    asserts++; if (rx_empty !== 1'b1) begin failures++; $display("FAIL reset_rx_empty: got %b expected 1", rx_empty); end
    asserts++; if (tx_full !== 1'b0) begin failures++; $display("FAIL reset_tx_full: got %b expected 0", tx_full); end
    asserts++; if (rx_count !== 5'd0 || tx_count !== 5'd0) begin failures++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", rx_count, tx_count); end
    asserts++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_rx_burst();
    logic [7:0] exp_b[3];
    logic [DL:0] peak;
    exp_b = '{8'h11, 8'h22, 8'h33};
    peak = '0;
    clear_logs();
    chip_rx_q = {8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 80; i++) begin
      tick(1);
      if (rx_count > peak) peak = rx_count;
    end
    asserts++; if (peak !== 5'd3) begin failures++; $display("FAIL rx_burst_peak: got %0d expected 3", peak); end
    asserts++; if (rd_len_q.size() != 3) begin failures++; $display("FAIL rx_burst_strobes: got %0d expected 3", rd_len_q.size()); end
    foreach (rd_len_q[i]) begin
      asserts++; if (rd_len_q[i] != 5) begin failures++; $display("FAIL rx_burst_rd_len%0d: got %0d expected 5", i, rd_len_q[i]); end
    end
    asserts++; if (gap_q.size() != 2) begin failures++; $display("FAIL rx_burst_gaps: got %0d expected 2", gap_q.size()); end
    foreach (gap_q[i]) begin
      asserts++; if (gap_q[i] < 4) begin failures++; $display("FAIL rx_burst_gap%0d: got %0d expected >=4", i, gap_q[i]); end
    end
    for (int i = 0; i < 3; i++) begin
      pop_rx();
      asserts++; if (rx_rdata !== exp_b[i]) begin failures++; $display("FAIL rx_burst_data%0d: got %h expected %h", i, rx_rdata, exp_b[i]); end
    end
    asserts++; if (rx_count !== 5'd0 || rx_empty !== 1'b1) begin failures++; $display("FAIL rx_burst_drain: got count %0d empty %b expected 0/1", rx_count, rx_empty); end
  endtask

  task automatic test_tx_burst();
    clear_logs();
    push_tx(8'hA5);
    push_tx(8'h5A);
    chip_txe_n = 1'b0;
    tick(60);
    asserts++; if (chip_tx_got.size() != 2) begin failures++; $display("FAIL tx_burst_count: got %0d bytes expected 2", chip_tx_got.size()); end
    else begin
      asserts++; if (chip_tx_got[0] !== 8'hA5) begin failures++; $display("FAIL tx_burst_b0: got %h expected a5", chip_tx_got[0]); end
      asserts++; if (chip_tx_got[1] !== 8'h5A) begin failures++; $display("FAIL tx_burst_b1: got %h expected 5a", chip_tx_got[1]); end
    end
    foreach (wr_len_q[i]) begin
      asserts++; if (wr_len_q[i] != 4) begin failures++; $display("FAIL tx_burst_wr_len%0d: got %0d expected 4", i, wr_len_q[i]); end
    end
    asserts++; if (setup_err != 0) begin failures++; $display("FAIL tx_burst_setup: got %0d bad setups expected 0", setup_err); end
    asserts++; if (tx_count !== 5'd0) begin failures++; $display("FAIL tx_burst_drain: got %0d expected 0", tx_count); end
    chip_txe_n = 1'b1;
    tick(4);
  endtask

  task automatic test_backpressure();
    int bad;
    bool_wait: begin end
    clear_logs();
    for (int i = 0; i < 20; i++) chip_rx_q.push_back(8'h40 + 8'(i));
    tick(250);
    asserts++; if (rx_count !== 5'd16 || rx_empty !== 1'b0) begin failures++; $display("FAIL bp_rx_full: got count %0d empty %b expected 16/0", rx_count, rx_empty); end
    tick(40);
    asserts++; if (rd_len_q.size() != 16) begin failures++; $display("FAIL bp_rx_strobes: got %0d expected 16", rd_len_q.size()); end
    chip_rx_q.delete();
    tick(5);
    for (int i = 0; i < 16; i++) begin
      pop_rx();
      asserts++; if (rx_rdata !== 8'h40 + 8'(i)) begin failures++; $display("FAIL bp_rx_data%0d: got %h expected %h", i, rx_rdata, 8'h40 + 8'(i)); end
    end
    asserts++; if (rx_count !== 5'd0) begin failures++; $display("FAIL bp_rx_drain: got %0d expected 0", rx_count); end

    clear_logs();
    for (int i = 0; i < 17; i++) push_tx(8'h80 + 8'(i));
    asserts++; if (tx_full !== 1'b1 || tx_count !== 5'd16) begin failures++; $display("FAIL bp_tx_full: got full %b count %0d expected 1/16", tx_full, tx_count); end
    chip_txe_n = 1'b0;
    tick(220);
    asserts++; if (chip_tx_got.size() != 16) begin failures++; $display("FAIL bp_tx_sent: got %0d bytes expected 16", chip_tx_got.size()); end
    foreach (chip_tx_got[i]) begin
      asserts++; if (chip_tx_got[i] !== 8'h80 + 8'(i)) begin failures++; $display("FAIL bp_tx_b%0d: got %h expected %h", i, chip_tx_got[i], 8'h80 + 8'(i)); end
    end
    asserts++; if (tx_count !== 5'd0 || tx_full !== 1'b0) begin failures++; $display("FAIL bp_tx_drain: got count %0d full %b expected 0/0", tx_count, tx_full); end
    chip_txe_n = 1'b1;
    tick(4);

    // Write held while the sequencer pops at full: count must stay 16.
    clear_logs();
    for (int i = 0; i < 16; i++) push_tx(8'hC0 + 8'(i));
    asserts++; if (tx_count !== 5'd16) begin failures++; $display("FAIL edge_tx_fill: got %0d expected 16", tx_count); end
    bad = 0;
    tx_write = 1'b1; tx_wdata = 8'hEE; chip_txe_n = 1'b0;
    for (int i = 0; i < 50 && chip_tx_got.size() == 0; i++) begin
      tick(1);
      if (tx_count !== 5'd16) bad++;
    end
    tx_write = 1'b0;
    asserts++; if (chip_tx_got.size() == 0) begin failures++; $display("FAIL edge_tx_timeout: got no write strobe expected one within 50 cycles"); end
    asserts++; if (bad != 0) begin failures++; $display("FAIL edge_tx_count: got %0d cycles off 16 expected 0", bad); end
    tick(200);
    asserts++; if (chip_tx_got.size() != 17) begin failures++; $display("FAIL edge_tx_sent: got %0d bytes expected 17", chip_tx_got.size()); end
    else begin
      asserts++; if (chip_tx_got[0] !== 8'hC0 || chip_tx_got[16] !== 8'hEE) begin failures++; $display("FAIL edge_tx_order: got %h..%h expected c0..ee", chip_tx_got[0], chip_tx_got[16]); end
    end
    chip_txe_n = 1'b1;
    tick(4);
  endtask

  task automatic test_contention();
    logic [7:0] exp_s[4];
    exp_s = '{8'h52, 8'h57, 8'h52, 8'h57};
    do_reset();
    push_tx(8'hB1);
    push_tx(8'hB2);
    chip_rx_q = {8'hD1, 8'hD2};
    tick(1);
    chip_txe_n = 1'b0;
    tick(80);
    asserts++; if (strobe_log.size() != 4) begin failures++; $display("FAIL cont_strobes: got %0d expected 4", strobe_log.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        asserts++; if (strobe_log[i] !== exp_s[i]) begin failures++; $display("FAIL cont_order%0d: got %c expected %c", i, strobe_log[i], exp_s[i]); end
      end
    end
    asserts++; if (mon_err != 0) begin failures++; $display("FAIL cont_overlap: got %0d violations expected 0", mon_err); end
    asserts++; if (chip_tx_got.size() != 2 || chip_tx_got[0] !== 8'hB1) begin failures++; $display("FAIL cont_tx: got %0d bytes expected b1,b2", chip_tx_got.size()); end
    pop_rx();
    asserts++; if (rx_rdata !== 8'hD1) begin failures++; $display("FAIL cont_rx0: got %h expected d1", rx_rdata); end
    pop_rx();
    asserts++; if (rx_rdata !== 8'hD2) begin failures++; $display("FAIL cont_rx1: got %h expected d2", rx_rdata); end
    chip_txe_n = 1'b1;
    tick(4);
  endtask

  task automatic test_rx_flush();
    int waited;
    clear_logs();
    chip_rx_q = {8'h77};
    waited = 0;
    while (usb_rd_n !== 1'b0 && waited < 50) begin tick(1); waited++; end
    asserts++; if (usb_rd_n !== 1'b0) begin failures++; $display("FAIL flush_timeout: got rd_n %b expected 0 within 50 cycles", usb_rd_n); end
    rx_flush = 1'b1;
    tick(1);
    rx_flush = 1'b0;
    tick(20);
    asserts++; if (rx_count !== 5'd0 || rx_empty !== 1'b1) begin failures++; $display("FAIL flush_count: got %0d empty %b expected 0/1", rx_count, rx_empty); end
    asserts++; if (rd_len_q.size() != 1 || rd_len_q[0] != 5) begin failures++; $display("FAIL flush_strobe: got %0d strobes expected one of 5 cycles", rd_len_q.size()); end
  endtask

  task automatic test_empty_read();
    chip_rx_q = {8'h3C};
    tick(30);
    asserts++; if (rx_count !== 5'd1) begin failures++; $display("FAIL empty_fill: got %0d expected 1", rx_count); end
    pop_rx();
    asserts++; if (rx_rdata !== 8'h3C) begin failures++; $display("FAIL empty_pop: got %h expected 3c", rx_rdata); end
    pop_rx();
    asserts++; if (rx_rdata !== 8'h3C) begin failures++; $display("FAIL empty_hold: got %h expected 3c", rx_rdata); end
    asserts++; if (rx_count !== 5'd0 || rx_empty !== 1'b1) begin failures++; $display("FAIL empty_flags: got %0d empty %b expected 0/1", rx_count, rx_empty); end
  endtask

  task automatic test_reset_mid_write();
    int waited;
    clear_logs();
    push_tx(8'hE1);
    push_tx(8'hE2);
    chip_txe_n = 1'b0;
    waited = 0;
    while (usb_wr_n !== 1'b0 && waited < 50) begin tick(1); waited++; end
    asserts++; if (usb_wr_n !== 1'b0) begin failures++; $display("FAIL rstw_timeout: got wr_n %b expected 0 within 50 cycles", usb_wr_n); end
    asserts++; if (tx_count !== 5'd1) begin failures++; $display("FAIL rstw_pre_count: got %0d expected 1", tx_count); end
    reset = 1'b1;
    chip_txe_n = 1'b1;
    tick(1);
    asserts++; if (usb_wr_n !== 1'b1 || usb_data_oe !== 1'b0) begin failures++; $display("FAIL rstw_strobe: got wr_n %b oe %b expected 1/0", usb_wr_n, usb_data_oe); end
    asserts++; if (tx_count !== 5'd0 || rx_count !== 5'd0) begin failures++; $display("FAIL rstw_counts: got %0d/%0d expected 0/0", tx_count, rx_count); end
    asserts++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL rstw_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    reset = 1'b0;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_rx_burst();
    test_tx_burst();
    test_backpressure();
    test_contention();
    test_rx_flush();
    test_empty_read();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
